// File: rtl/interrupt_pkg_8259a.sv
// Shared types and helpers for the 8259A acknowledge path: FSM states,
// level/one-hot conversion and 8-bit circular rotates.
package interrupt_pkg_8259a;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } ack_state_t;

  function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
    return 8'b0000_0001 << level;
  endfunction

  // Highest set bit wins; inputs are expected to be one-hot anyway.
  function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
    logic [2:0] level;
    level = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) level = 3'(i);
    end
    return level;
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] data, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {data, data} << amount;
    return doubled[15:8];
  endfunction

  function automatic logic [7:0] rotate_right(input logic [7:0] data, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {data, data} >> amount;
    return doubled[7:0];
  endfunction

endpackage

// File: rtl/in_service_resolver_8259a.sv
// Picks the highest-priority in-service level under the current rotation.
// Purely combinational, no handshake.
module in_service_resolver_8259a
  import interrupt_pkg_8259a::*;
(
  input  logic [7:0] in_service_register,
  input  logic [2:0] priority_rotate,
  output logic [7:0] highest_level_in_service
);

  logic [2:0] start_level;
  logic [7:0] rotated;
  logic [7:0] lowest_bit;

  // Rotate so the level just above the lowest-priority one lands in bit 0,
  // isolate the lowest set bit, then rotate back.
  assign start_level = priority_rotate + 3'd1;
  assign rotated     = rotate_right(in_service_register, start_level);
  assign lowest_bit  = rotated & (~rotated + 8'd1);

  assign highest_level_in_service = rotate_left(lowest_bit, start_level);

endmodule

// File: rtl/acknowledge_control_8259a.sv
// 8259A INTA sequencing: raises INT, sets ISR on pulse 1, drives the vector on pulse 2, handles EOI.
// Latency: INT and clear pulse register one cycle after the qualifying input; bus follows INTA by one cycle.
// No backpressure; SPURIOUS_IRQ7_EN turns an empty first INTA into a level-7 vector cycle.
module acknowledge_control_8259a
  import interrupt_pkg_8259a::*;
#(
  parameter logic AUTO_ROTATE_DEFAULT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic [4:0] interrupt_vector_base,
  input  logic       auto_eoi_config,
  input  logic       auto_rotate_load,
  input  logic       auto_rotate_value,
  input  logic       end_of_interrupt,
  input  logic       specific_eoi,
  input  logic [2:0] eoi_level,
  input  logic       interrupt_acknowledge_n,
  output logic       interrupt_to_cpu,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_bus_out,
  output logic       out_control_data_bus
);

  ack_state_t state_q, state_nxt;
  logic       inta_n_q;
  logic       inta_fall, inta_rise;
  logic       auto_rotate_q;
  logic [2:0] level_q, level_nxt;
  logic [7:0] isr_nxt;
  logic [2:0] rotate_nxt;
  logic [7:0] clr_nxt;
  logic       int_nxt;
  logic       drive_nxt;
  logic [2:0] request_level;
  logic [7:0] request_onehot;
`ifdef SPURIOUS_IRQ7_EN
  logic       spurious_q, spurious_nxt;
`endif

  assign inta_fall      = inta_n_q & ~interrupt_acknowledge_n;
  assign inta_rise      = ~inta_n_q & interrupt_acknowledge_n;
  assign request_level  = onehot_to_level(interrupt);
  assign request_onehot = level_to_onehot(request_level);

  in_service_resolver_8259a u_resolver (
    .in_service_register     (in_service_register),
    .priority_rotate         (priority_rotate),
    .highest_level_in_service(highest_level_in_service)
  );

  always_comb begin
    state_nxt  = state_q;
    level_nxt  = level_q;
    isr_nxt    = in_service_register;
    rotate_nxt = priority_rotate;
    clr_nxt    = 8'h00;
    int_nxt    = interrupt_to_cpu;
    drive_nxt  = 1'b0;
`ifdef SPURIOUS_IRQ7_EN
    spurious_nxt = spurious_q;
`endif

    // EOI clears are applied first so a same-cycle ACK1 set overrides them.
    if (specific_eoi) begin
      if (in_service_register[eoi_level]) begin
        isr_nxt[eoi_level] = 1'b0;
        if (auto_rotate_q) rotate_nxt = eoi_level;
      end
    end else if (end_of_interrupt && (highest_level_in_service != 8'h00)) begin
      isr_nxt = isr_nxt & ~highest_level_in_service;
      if (auto_rotate_q) rotate_nxt = onehot_to_level(highest_level_in_service);
    end

    case (state_q)
      IDLE: begin
        int_nxt = (interrupt != 8'h00);
        if (inta_fall) begin
          int_nxt = 1'b0;
          if (interrupt != 8'h00) begin
            level_nxt = request_level;
            isr_nxt   = isr_nxt | request_onehot;
            clr_nxt   = request_onehot;
            state_nxt = ACK1;
`ifdef SPURIOUS_IRQ7_EN
            spurious_nxt = 1'b0;
          end else begin
            level_nxt    = 3'd7;
            spurious_nxt = 1'b1;
            state_nxt    = ACK1;
`endif
          end
        end
      end
      ACK1: begin
        int_nxt = 1'b0;
        if (inta_rise) state_nxt = ACK2;
      end
      ACK2: begin
        int_nxt   = 1'b0;
        drive_nxt = ~interrupt_acknowledge_n;
        if (inta_rise) begin
          state_nxt = IDLE;
`ifdef SPURIOUS_IRQ7_EN
          if (auto_eoi_config && !spurious_q) begin
`else
          if (auto_eoi_config) begin
`endif
            isr_nxt[level_q] = 1'b0;
            if (auto_rotate_q) rotate_nxt = level_q;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                 <= IDLE;
      inta_n_q                <= 1'b1;
      auto_rotate_q           <= AUTO_ROTATE_DEFAULT;
      level_q                 <= 3'd0;
      in_service_register     <= 8'h00;
      priority_rotate         <= 3'b111;
      clear_interrupt_request <= 8'h00;
      interrupt_to_cpu        <= 1'b0;
      data_bus_out            <= 8'h00;
      out_control_data_bus    <= 1'b0;
`ifdef SPURIOUS_IRQ7_EN
      spurious_q              <= 1'b0;
`endif
    end else begin
      state_q                 <= state_nxt;
      inta_n_q                <= interrupt_acknowledge_n;
      level_q                 <= level_nxt;
      in_service_register     <= isr_nxt;
      priority_rotate         <= rotate_nxt;
      clear_interrupt_request <= clr_nxt;
      interrupt_to_cpu        <= int_nxt;
      out_control_data_bus    <= drive_nxt;
      data_bus_out            <= drive_nxt ? {interrupt_vector_base, level_q} : 8'h00;
      if (auto_rotate_load) auto_rotate_q <= auto_rotate_value;
`ifdef SPURIOUS_IRQ7_EN
      spurious_q              <= spurious_nxt;
`endif
    end
  end

endmodule
